debounce_multi: RTL and testbench

Parametrised, multi-channel push-button debouncer for the board's mechanical inputs. Each channel passes through a two-flop synchroniser, then a per-channel state machine that debounces both press and release. Each channel produces a stable level, single-cycle press/release strobes and an optional long-press strobe. The block sits between the raw pins and the game/control FSMs, replacing the single-channel, press-only debouncer.

---
 rtl/debounce_multi_if.sv | 26 ++
 rtl/debounce_multi.sv | 157 +++++++++++++++
 tb/tb_debounce_multi.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/debounce_multi_if.sv
// Button bundle between raw pins and the debouncer: raw inputs in, debounced level and strobes out.
interface debounce_multi_if #(
    parameter int unsigned N = 4
);
    logic [N-1:0] btn_in;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;
    logic [N-1:0] btn_long;

    modport master (
        output btn_in,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_long
    );

    modport slave (
        input  btn_in,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_long
    );
endinterface

// File: rtl/debounce_multi.sv
// Multi-channel push-button debouncer: two-flop synchroniser, then a per-channel
// press/release qualification FSM with registered level, press/release and long-press strobes.
module debounce_multi #(
    parameter int unsigned N             = 4,
    parameter int unsigned CNT_W         = 19,
    parameter int unsigned STABLE_CYCLES = 500000,
    parameter int unsigned LONG_W        = 26,
    parameter int unsigned LONG_CYCLES   = 0,
    parameter bit          ACTIVE_LOW    = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    debounce_multi_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CONF_PRESS = 2'd1,
        PRESSED    = 2'd2,
        CONF_REL   = 2'd3
    } state_t;

    localparam logic [N-1:0]      POL      = {N{ACTIVE_LOW}};
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [LONG_W-1:0] LONG_END = LONG_W'(LONG_CYCLES);
    localparam bit                LONG_EN  = (LONG_CYCLES != 0);

    // Elaboration-time guards: counters must never need to wrap.
    if (STABLE_CYCLES < 2 || 64'(STABLE_CYCLES) > ((64'(1) << CNT_W) - 64'(1))) begin : g_bad_stable
        $error("debounce_multi: STABLE_CYCLES out of range for CNT_W");
    end
    if (64'(LONG_CYCLES) > ((64'(1) << LONG_W) - 64'(1))) begin : g_bad_long
        $error("debounce_multi: LONG_CYCLES does not fit in LONG_W");
    end

    logic [N-1:0] sync1_q;
    logic [N-1:0] sync2_q;
    logic [N-1:0] level_v;
    logic [N-1:0] press_v;
    logic [N-1:0] release_v;
    logic [N-1:0] long_v;

    // Two-flop synchroniser; reset value 0 is the released level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.btn_in ^ POL;
            sync2_q <= sync1_q;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_ch
        state_t            state_q, state_d;
        logic [CNT_W-1:0]  cnt_q, cnt_d;
        logic [LONG_W-1:0] lcnt_q, lcnt_d;
        logic              level_q, level_d;
        logic              press_q, press_d;
        logic              rel_q, rel_d;
        logic              long_q, long_d;
        logic              s;

        assign s = sync2_q[i];

        // Channel state and registered outputs.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                lcnt_q  <= '0;
                level_q <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                long_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                lcnt_q  <= lcnt_d;
                level_q <= level_d;
                press_q <= press_d;
                rel_q   <= rel_d;
                long_q  <= long_d;
            end
        end

        // Next-state logic; any bounce inside a confirm window restarts qualification.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            lcnt_d  = lcnt_q;
            level_d = level_q;
            press_d = 1'b0;
            rel_d   = 1'b0;
            long_d  = 1'b0;
            case (state_q)
                IDLE: begin
                    if (s) begin
                        state_d = CONF_PRESS;
                        cnt_d   = CNT_W'(1);
                    end
                end
                CONF_PRESS: begin
                    if (!s) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = PRESSED;
                        level_d = 1'b1;
                        press_d = 1'b1;
                        lcnt_d  = '0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (!s) begin
                        state_d = CONF_REL;
                        cnt_d   = CNT_W'(1);
                    end else if (LONG_EN && lcnt_q != LONG_END) begin
                        lcnt_d = lcnt_q + LONG_W'(1);
                        long_d = (lcnt_q + LONG_W'(1)) == LONG_END;
                    end
                end
                CONF_REL: begin
                    if (s) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = IDLE;
                        level_d = 1'b0;
                        rel_d   = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        assign level_v[i]   = level_q;
        assign press_v[i]   = press_q;
        assign release_v[i] = rel_q;
        assign long_v[i]    = long_q;
    end

    assign bus.btn_level   = level_v;
    assign bus.btn_press   = press_v;
    assign bus.btn_release = release_v;
    assign bus.btn_long    = long_v;

endmodule

// File: tb/tb_debounce_multi.sv
// Scoreboard bench for debounce_multi: expected strobes are queued with their cycle
// when pins are driven, and matched against the strobes the DUT produces.
module tb_debounce_multi;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    debounce_multi_if #(.N(N)) bus_a ();
    debounce_multi_if #(.N(N)) bus_b ();

    debounce_multi #(
        .N(N), .CNT_W(4), .STABLE_CYCLES(8), .LONG_W(6), .LONG_CYCLES(20), .ACTIVE_LOW(1'b0)
    ) dut_a (
        .clk(clk),
        .rst(rst),
        .bus(bus_a)
    );

    debounce_multi #(
        .N(N), .CNT_W(4), .STABLE_CYCLES(8), .LONG_W(6), .LONG_CYCLES(20), .ACTIVE_LOW(1'b1)
    ) dut_b (
        .clk(clk),
        .rst(rst),
        .bus(bus_b)
    );

    typedef struct {
        int cyc;
        int code;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // kind: 1 = press, 2 = release, 3 = long
    function automatic int ev_code(input int c, input int kind, input int ch);
        return c * 100 + kind * 10 + ch;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic expect_ev(input int c, input int kind, input int ch);
        exp_t e;
        e.cyc  = c;
        e.code = ev_code(c, kind, ch);
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Strobe monitor for the active-high DUT: every strobe must match the queue head.
    always begin
        @(posedge clk);
        cyc++;
        #1;
        for (int kind = 1; kind <= 3; kind++) begin
            for (int ch = 0; ch < N; ch++) begin
                logic v;
                int   oc;
                v = (kind == 1) ? bus_a.btn_press[ch] :
                    (kind == 2) ? bus_a.btn_release[ch] : bus_a.btn_long[ch];
                if (v) begin
                    oc = ev_code(cyc, kind, ch);
                    if (sb.size() > 0 && sb[0].cyc == cyc) begin
                        check_val("evt", 32'(oc), 32'(sb[0].code));
                        void'(sb.pop_front());
                    end else begin
                        check_val("spur", 32'(oc), 32'd0);
                    end
                end
            end
        end
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            check_val("miss", 32'd0, 32'(sb[0].code));
            void'(sb.pop_front());
        end
    end

    initial begin
        int e0;
        bus_a.btn_in = '0;
        bus_b.btn_in = '1;
        rst = 1'b1;
        step(2);
        check_val("rst_lvl_a", 32'(bus_a.btn_level), 32'd0);
        check_val("rst_str_a", 32'(bus_a.btn_press | bus_a.btn_release | bus_a.btn_long), 32'd0);
        check_val("rst_lvl_b", 32'(bus_b.btn_level), 32'd0);
        rst = 1'b0;

        // Idle pins: nothing happens.
        step(50);
        check_val("idle_lvl_a", 32'(bus_a.btn_level), 32'd0);
        check_val("idle_lvl_b", 32'(bus_b.btn_level), 32'd0);

        // Clean press, long press and release on ch0.
        e0 = cyc;
        bus_a.btn_in[0] = 1'b1;
        expect_ev(e0 + 10, 1, 0);
        expect_ev(e0 + 30, 3, 0);
        step(9);
        check_val("t2_pre", 32'(bus_a.btn_level[0]), 32'd0);
        step(1);
        check_val("t2_lvl", 32'(bus_a.btn_level[0]), 32'd1);
        step(30);
        bus_a.btn_in[0] = 1'b0;
        expect_ev(e0 + 50, 2, 0);
        step(9);
        check_val("t2_hold", 32'(bus_a.btn_level[0]), 32'd1);
        step(1);
        check_val("t2_rel", 32'(bus_a.btn_level[0]), 32'd0);
        step(5);

        // Bouncing press on ch1: qualifies only from the last rising edge.
        e0 = cyc;
        bus_a.btn_in[1] = 1'b1;
        step(3);
        bus_a.btn_in[1] = 1'b0;
        step(3);
        bus_a.btn_in[1] = 1'b1;
        expect_ev(e0 + 16, 1, 1);
        expect_ev(e0 + 36, 3, 1);
        step(9);
        check_val("t3_pre", 32'(bus_a.btn_level[1]), 32'd0);
        step(1);
        check_val("t3_lvl", 32'(bus_a.btn_level[1]), 32'd1);
        step(24);
        bus_a.btn_in[1] = 1'b0;
        expect_ev(e0 + 50, 2, 1);
        step(15);

        // Ch2 release glitch: level held, long count paused during the glitch.
        e0 = cyc;
        bus_a.btn_in[2] = 1'b1;
        expect_ev(e0 + 10, 1, 2);
        step(15);
        bus_a.btn_in[2] = 1'b0;
        step(5);
        bus_a.btn_in[2] = 1'b1;
        expect_ev(e0 + 36, 3, 2);
        step(2);
        check_val("t4_glitch_lvl", 32'(bus_a.btn_level[2]), 32'd1);
        step(18);
        bus_a.btn_in[2] = 1'b0;
        expect_ev(e0 + 50, 2, 2);
        step(15);

        // Simultaneous press on ch0/ch3, reset while held, re-qualification.
        e0 = cyc;
        bus_a.btn_in = 4'b1001;
        bus_b.btn_in = 4'b0110;
        expect_ev(e0 + 10, 1, 0);
        expect_ev(e0 + 10, 1, 3);
        step(9);
        check_val("t5_pre_b", 32'(bus_b.btn_press), 32'd0);
        step(1);
        check_val("t5_press_b", 32'(bus_b.btn_press), 32'b1001);
        check_val("t5_lvl_a", 32'(bus_a.btn_level), 32'b1001);
        check_val("t5_lvl_b", 32'(bus_b.btn_level), 32'b1001);
        step(5);
        #2;
        rst = 1'b1;
        #1;
        check_val("t5_async_a", 32'(bus_a.btn_level), 32'd0);
        check_val("t5_async_b", 32'(bus_b.btn_level), 32'd0);
        step(2);
        check_val("t5_inrst_rel", 32'(bus_a.btn_release | bus_b.btn_release), 32'd0);
        rst = 1'b0;
        expect_ev(e0 + 27, 1, 0);
        expect_ev(e0 + 27, 1, 3);
        step(9);
        check_val("t5_repre_a", 32'(bus_a.btn_level), 32'd0);
        step(1);
        check_val("t5_repress_b", 32'(bus_b.btn_press), 32'b1001);
        check_val("t5_relvl_a", 32'(bus_a.btn_level), 32'b1001);
        step(8);
        bus_a.btn_in = '0;
        bus_b.btn_in = '1;
        expect_ev(e0 + 45, 2, 0);
        expect_ev(e0 + 45, 2, 3);
        step(10);
        check_val("t5_rel_b", 32'(bus_b.btn_release), 32'b1001);
        check_val("t5_rellvl_b", 32'(bus_b.btn_level), 32'd0);
        step(25);

        while (sb.size() > 0) begin
            check_val("left", 32'd0, 32'(sb[0].code));
            void'(sb.pop_front());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
